// File: rtl/jtoutrun_obj_pkg.sv
// Shared definitions for the OutRun object line buffer.
// Provides the FSM state type, the blank-pixel constructor, priority field
// extraction and modulo-BANKS bank stepping used by the buffer and its
// write-path sub-module.
package jtoutrun_obj_pkg;

   typedef enum logic {StClear, StRun} state_t;

   // Pixel word that is all zeros except the transparency field, which holds alpha.
   function automatic logic [63:0] blank_word(input int unsigned abits, input int unsigned alpha);
      logic [63:0] mask;
      mask = (64'd1 << abits) - 64'd1;
      return {32'd0, alpha} & mask;
   endfunction

   // Two-bit priority field starting at bit lsb of a pixel word.
   function automatic logic [1:0] prio_of(input logic [63:0] word, input int unsigned lsb);
      return 2'(word >> lsb);
   endfunction

   function automatic logic [1:0] bank_next(input logic [1:0] wb, input int unsigned banks);
      return (({30'd0, wb} + 32'd1) >= banks) ? 2'd0 : wb + 2'd1;
   endfunction

   function automatic logic [1:0] bank_prev(input logic [1:0] wb, input int unsigned banks);
      return (wb == 2'd0) ? 2'(banks - 32'd1) : wb - 2'd1;
   endfunction

endpackage

// File: rtl/jtoutrun_obj_lnbuf_wr.sv
// Draw-side write path of the object line buffer.
// Drops transparent pixels and, when PRIO_EN is set, compares the new pixel
// priority against the stored word (read the cycle of we, compared the next
// cycle) with forwarding of the commit happening on the same edge.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    high once the clear sweep is over
//   we, wr_bank, wr_addr, wr_data   draw write request
//   stored                memory word read at {wr_bank, wr_addr} one cycle earlier
//   commit, commit_addr, commit_data  memory write toward port A
module jtoutrun_obj_lnbuf_wr import jtoutrun_obj_pkg::*; #(
   parameter int unsigned DW       = 14,
   parameter int unsigned AW       = 9,
   parameter int unsigned BW       = 1,
   parameter int unsigned ABITS    = 4,
   parameter int unsigned ALPHA    = 0,
   parameter int unsigned PRIO_EN  = 1,
   parameter int unsigned PRIO_LSB = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             we,
   input  logic [BW-1:0]    wr_bank,
   input  logic [AW-1:0]    wr_addr,
   input  logic [DW-1:0]    wr_data,
   input  logic [DW-1:0]    stored,
   output logic             commit,
   output logic [BW+AW-1:0] commit_addr,
   output logic [DW-1:0]    commit_data
);

   localparam int unsigned      FW      = BW + AW;
   localparam logic [ABITS-1:0] ALPHA_V = ABITS'(ALPHA);

   logic          accept;
   logic [FW-1:0] new_addr;

   assign accept   = en & we & (wr_data[ABITS-1:0] != ALPHA_V);
   assign new_addr = {wr_bank, wr_addr};

   if (PRIO_EN != 0) begin : g_prio
      logic          s1_valid;
      logic [FW-1:0] s1_addr;
      logic [DW-1:0] s1_data;
      logic          fwd_hit;
      logic [DW-1:0] fwd_data;
      logic [DW-1:0] old_word;
      logic          old_clear;
      logic          win;

      // The memory read taken on the accept edge misses a commit landing on
      // that same edge; the forwarding register supplies that word instead.
      always_comb begin
         old_word  = fwd_hit ? fwd_data : stored;
         old_clear = (old_word[ABITS-1:0] == ALPHA_V);
         win       = prio_of(64'(s1_data), PRIO_LSB) >= prio_of(64'(old_word), PRIO_LSB);
      end

      assign commit      = s1_valid & (old_clear | win);
      assign commit_addr = s1_addr;
      assign commit_data = s1_data;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
         end else begin
            s1_valid <= accept;
            if (accept) begin
               s1_addr <= new_addr;
               s1_data <= wr_data;
            end
            fwd_hit  <= accept & commit & (s1_addr == new_addr);
            fwd_data <= s1_data;
         end
      end
   end else begin : g_direct
      logic unused_direct;
      assign unused_direct = ^{clk, rst_n, stored};
      assign commit        = accept;
      assign commit_addr   = new_addr;
      assign commit_data   = wr_data;
   end

endmodule

// File: rtl/jtoutrun_obj_lnbuf.sv
// Parametrised object line buffer between the object draw engine and the mixer.
// BANKS line banks rotate on each LHBL fall: the draw engine writes bank wb
// while the mixer reads (and erases behind itself) bank wb-1.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   pxl_cen          pixel clock enable for the read side
//   LHBL, flip       horizontal blank (active low), screen flip
//   wr_addr, wr_data, we   draw write request
//   pxl              output pixel, registered
//   ln_swap          one-cycle pulse after each bank rotation
//   clr_busy         high while the power-up clear sweep runs
module jtoutrun_obj_lnbuf import jtoutrun_obj_pkg::*; #(
   parameter int unsigned DW       = 14,
   parameter int unsigned AW       = 9,
   parameter int unsigned BANKS    = 2,
   parameter int unsigned ABITS    = 4,
   parameter int unsigned ALPHA    = 0,
   parameter int unsigned PRIO_EN  = 1,
   parameter int unsigned PRIO_LSB = 12,
   parameter int unsigned PXL_DLY  = 8,
   parameter int unsigned HSTART   = 'haa
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pxl_cen,
   input  logic          LHBL,
   input  logic          flip,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          we,
   output logic [DW-1:0] pxl,
   output logic          ln_swap,
   output logic          clr_busy
);

   localparam int unsigned   BW        = $clog2(BANKS);
   localparam int unsigned   FW        = BW + AW;
   localparam int unsigned   WORDS     = BANKS << AW;
   localparam logic [DW-1:0] BLANK     = DW'(blank_word(ABITS, ALPHA));
   localparam logic [AW-1:0] RD_START  = AW'(HSTART - PXL_DLY);
   // Mirrored start for a flipped screen, taken modulo 2^AW.
   localparam logic [AW-1:0] RD_FSTART = AW'((1 << AW) - 1 + 'hc0 - (HSTART - PXL_DLY));
   localparam logic [FW-1:0] CLR_LAST  = FW'(WORDS - 1);

   logic [DW-1:0] mem [WORDS];

   state_t        state_q, state_d;
   logic [FW-1:0] clr_addr_q;
   logic [BW-1:0] wb_q;
   logic [BW-1:0] rb;
   logic          lhbl_q;
   logic          ln_swap_q;
   logic [AW-1:0] rd_cnt_q;
   logic [DW-1:0] pxl_q;
   logic [DW-1:0] a_rd_q;
   logic          run;
   logic          fall;
   logic          rd_en;
   logic [FW-1:0] rd_addr;
   logic          commit;
   logic [FW-1:0] commit_addr;
   logic [DW-1:0] commit_data;
   logic          a_we;
   logic [FW-1:0] a_addr;
   logic [DW-1:0] a_data;

   assign run     = (state_q == StRun);
   assign fall    = run & lhbl_q & ~LHBL;
   assign rb      = BW'(bank_prev(2'(wb_q), BANKS));
   assign rd_en   = run & LHBL & pxl_cen;
   assign rd_addr = {rb, rd_cnt_q};

   assign a_we    = ~run | commit;
   assign a_addr  = run ? commit_addr : clr_addr_q;
   assign a_data  = run ? commit_data : BLANK;

   assign pxl      = pxl_q;
   assign ln_swap  = ln_swap_q;
   assign clr_busy = ~run;

   jtoutrun_obj_lnbuf_wr #(
      .DW       (DW),
      .AW       (AW),
      .BW       (BW),
      .ABITS    (ABITS),
      .ALPHA    (ALPHA),
      .PRIO_EN  (PRIO_EN),
      .PRIO_LSB (PRIO_LSB)
   ) u_wr (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (run),
      .we          (we),
      .wr_bank     (wb_q),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .stored      (a_rd_q),
      .commit      (commit),
      .commit_addr (commit_addr),
      .commit_data (commit_data)
   );

   always_comb begin
      state_d = state_q;
      if (state_q == StClear && clr_addr_q == CLR_LAST) state_d = StRun;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StClear;
         clr_addr_q <= '0;
         wb_q       <= '0;
         lhbl_q     <= 1'b0;
         ln_swap_q  <= 1'b0;
         rd_cnt_q   <= RD_START;
         pxl_q      <= BLANK;
      end else begin
         state_q   <= state_d;
         lhbl_q    <= LHBL;
         ln_swap_q <= fall;
         if (!run) clr_addr_q <= clr_addr_q + FW'(1);
         if (fall) wb_q <= BW'(bank_next(2'(wb_q), BANKS));
         if (!LHBL) begin
            rd_cnt_q <= flip ? RD_FSTART : RD_START;
         end else if (pxl_cen) begin
            rd_cnt_q <= flip ? rd_cnt_q - AW'(1) : rd_cnt_q + AW'(1);
         end
         if (rd_en) pxl_q <= mem[rd_addr];
      end
   end

   // Port A: clear sweep or draw commit, plus the priority read.
   // Port B: read-erase behind the mixer, always in the read bank.
   always_ff @(posedge clk) begin
      a_rd_q <= mem[{wb_q, wr_addr}];
      if (a_we) mem[a_addr] <= a_data;
      if (rd_en) mem[rd_addr] <= BLANK;
   end

endmodule
